// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: reads 16-bit words from synchronous instruction memory,
// splits them into opcode/operand fields for control_unit and steps the program counter.
module instr_fetch_unit #(
    parameter int unsigned PC_W    = 8,
    parameter logic [7:0]  HALT_OP = 8'hFF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [15:0]     imem_data,
    input  logic            cu_ready,
    input  logic            pc_load,
    input  logic [PC_W-1:0] pc_load_val,
    output logic [7:0]      addr_ins,
    output logic [3:0]      operand1,
    output logic [3:0]      operand2,
    output logic            en,
    output logic [PC_W-1:0] pc,
    output logic            running
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_EXEC  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t          state;
    logic [15:0]     ir;
    logic [PC_W-1:0] next_pc;

    // Address of the instruction that follows the one now executing.
    always_comb begin
        next_pc = pc + PC_W'(1);
        if (pc_load) begin
            next_pc = pc_load_val;
        end
    end

    assign addr_ins = ir[15:8];
    assign operand1 = ir[7:4];
    assign operand2 = ir[3:0];

    // Sequencer; imem_rd, en and running are set on the edge entering the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir        <= '0;
            imem_addr <= '0;
            imem_rd   <= 1'b0;
            en        <= 1'b0;
            running   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    en <= 1'b0;
                    if (start) begin
                        state     <= S_FETCH;
                        pc        <= '0;
                        imem_addr <= '0;
                        imem_rd   <= 1'b1;
                        running   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    imem_rd <= 1'b0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    ir <= imem_data;
                    if (imem_data[15:8] == HALT_OP) begin
                        state   <= S_HALT;
                        running <= 1'b0;
                    end else begin
                        state <= S_ISSUE;
                        en    <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    en    <= 1'b0;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (cu_ready) begin
                        pc        <= next_pc;
                        imem_addr <= next_pc;
                        imem_rd   <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    imem_rd <= 1'b0;
                    en      <= 1'b0;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: an instruction-level program model
// predicts fetch addresses, issued instructions and halts; a negedge monitor checks them.
module tb_instr_fetch_unit;

    localparam int unsigned PC_W    = 8;
    localparam logic [7:0]  HALT_OP = 8'hFF;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rd;
    logic [15:0]     imem_data;
    logic            cu_ready;
    logic            pc_load;
    logic [PC_W-1:0] pc_load_val;
    logic [7:0]      addr_ins;
    logic [3:0]      operand1;
    logic [3:0]      operand2;
    logic            en;
    logic [PC_W-1:0] pc;
    logic            running;

    instr_fetch_unit #(.PC_W(PC_W), .HALT_OP(HALT_OP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
        .cu_ready(cu_ready), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .addr_ins(addr_ins), .operand1(operand1), .operand2(operand2),
        .en(en), .pc(pc), .running(running)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data appears the cycle after the read strobe.
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program counter stepping through memory at instruction granularity.
    logic [7:0]  fq[$];   // expected fetch addresses
    logic [23:0] iq[$];   // expected issues {pc, word}
    logic [23:0] hq[$];   // expected halts {pc, word}
    logic [7:0]  mpc;

    function automatic void model_fetch();
        logic [15:0] w;
        w = mem[mpc];
        fq.push_back(mpc);
        if (w[15:8] == HALT_OP) hq.push_back({mpc, w});
        else                    iq.push_back({mpc, w});
    endfunction

    function automatic void model_start();
        mpc = 8'd0;
        model_fetch();
    endfunction

    function automatic void model_take(input logic jump, input logic [7:0] tgt);
        mpc = jump ? tgt : 8'(mpc + 8'd1);
        model_fetch();
    endfunction

    // Monitor: compares every fetch, issue and halt the DUT presents against the queues.
    int   cyc = 0;
    int   last_rd = -100;
    logic prev_running = 1'b0;
    always @(negedge clk) begin
        logic [23:0] e;
        cyc++;
        if (!rst_n) begin
            prev_running = 1'b0;
        end else begin
            if (imem_rd) begin
                if (fq.size() == 0) chk("spurious_fetch", 32'(imem_addr), 32'hDEAD);
                else                chk("fetch_addr", 32'(imem_addr), 32'(fq.pop_front()));
                last_rd = cyc;
            end
            if (en) begin
                if (iq.size() == 0) chk("spurious_issue", {addr_ins, operand1, operand2}, 32'hDEAD);
                else begin
                    e = iq.pop_front();
                    chk("issue_fields", {addr_ins, operand1, operand2}, 32'(e[15:0]));
                    chk("issue_pc", 32'(pc), 32'(e[23:16]));
                    chk("rd_to_en_latency", 32'(cyc - last_rd), 32'd2);
                end
            end
            if (prev_running && !running) begin
                if (hq.size() == 0) chk("spurious_halt", 32'(pc), 32'hDEAD);
                else begin
                    e = hq.pop_front();
                    chk("halt_pc_ir", {en, pc, addr_ins, operand1, operand2}, {1'b0, e});
                end
            end
            prev_running = running;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        got_en, halted, jump, done;
        logic [7:0]  tgt;
        logic [15:0] w;
        int          n, limit, k, t;

        rst_n = 1'b0; start = 1'b0; cu_ready = 1'b0; pc_load = 1'b0; pc_load_val = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        #2;
        chk("reset_outputs", {en, imem_rd, running, imem_addr, pc, addr_ins, operand1, operand2},
            32'h0);
        tick(); tick();
        rst_n = 1'b1;
        // Idle with noisy handshake inputs: nothing may move without start.
        for (int i = 0; i < 6; i++) begin
            cu_ready = 1'($urandom); pc_load = 1'($urandom); pc_load_val = 8'($urandom);
            tick();
        end
        chk("idle_outputs", {en, imem_rd, running, imem_addr, pc, addr_ins, operand1, operand2},
            32'h0);

        for (int ep = 0; ep < 30; ep++) begin
            cu_ready = 1'b0; pc_load = 1'b0;
            if (ep == 0) begin
                mem[0] = 16'h2801; mem[1] = 16'hFF00;
            end else if (ep == 1) begin
                mem[0] = 16'h1000; mem[1] = 16'hFF00; mem[5] = 16'h2012; mem[6] = 16'hFF00;
            end else begin
                for (int i = 0; i < 256; i++) begin
                    w = 16'($urandom);
                    if ($urandom_range(0, 9) == 0) w[15:8] = HALT_OP;
                    else if (w[15:8] == HALT_OP) w[15:8] = 8'h00;
                    mem[i] = w;
                end
            end
            limit = (ep % 4 == 3) ? int'($urandom_range(1, 5)) : 40;

            start = 1'b1;
            model_start();
            tick();
            start = 1'b0;
            n = 0;
            done = 1'b0;
            while (!done) begin
                got_en = 1'b0; halted = 1'b0;
                for (t = 0; t < 20 && !got_en && !halted; t++) begin
                    tick();
                    if (en) got_en = 1'b1;
                    else if (!running) halted = 1'b1;
                end
                if (!got_en && !halted) begin
                    chk("progress_timeout", 32'(t), 32'h0);
                    done = 1'b1;
                end else if (halted) begin
                    done = 1'b1;
                end else begin
                    n++;
                    if (n >= limit) begin
                        // Asynchronous reset while the instruction is being issued.
                        #5 rst_n = 1'b0;
                        #1 chk("reset_in_issue", {en, imem_rd, running, pc, imem_addr, addr_ins},
                               32'h0);
                        tick(); tick();
                        rst_n = 1'b1;
                        fq.delete(); iq.delete(); hq.delete();
                        done = 1'b1;
                    end else begin
                        // ISSUE cycle: handshake/start noise must be ignored.
                        cu_ready = 1'($urandom); pc_load = 1'($urandom);
                        pc_load_val = 8'($urandom); start = ($urandom_range(0, 3) == 0);
                        tick();
                        start = 1'b0;
                        k = (ep == 0) ? 0 : int'($urandom_range(0, 4));
                        if (ep == 5) k = 10;
                        for (int s = 0; s < k; s++) begin
                            cu_ready = 1'b0; pc_load = 1'($urandom); pc_load_val = 8'($urandom);
                            start = ($urandom_range(0, 4) == 0);
                            tick();
                            chk("exec_stall", {en, imem_rd, running, pc, addr_ins, operand1, operand2},
                                {1'b0, 1'b0, 1'b1, mpc, mem[mpc]});
                        end
                        start = 1'b0;
                        jump = (ep == 1 && n == 1) ? 1'b1 : (ep != 0 && $urandom_range(0, 3) == 0);
                        tgt  = (ep == 1) ? 8'd5 : (($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
                        cu_ready = 1'b1; pc_load = jump; pc_load_val = tgt;
                        model_take(jump, tgt);
                        tick();
                        cu_ready = 1'b0; pc_load = 1'b0;
                        chk("pc_after_ready", 32'(pc), 32'(mpc));
                    end
                end
            end
            // Quiet period in HALT/IDLE with noisy handshake inputs.
            for (int i = 0; i < 3; i++) begin
                cu_ready = 1'($urandom); pc_load = 1'($urandom); pc_load_val = 8'($urandom);
                tick();
            end
            chk("stopped_not_running", {running, en, imem_rd}, 32'h0);
        end

        repeat (4) tick();
        chk("queues_drained", 32'(fq.size() + iq.size() + hq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
